alu_cmd_ctrl: RTL and testbench

Byte-oriented command controller that sequences the registered arithmetic unit. It collects operand and function bytes from the receive path, drives the ALU's operands, function select and enable for exactly one cycle, captures the registered result, and returns a result byte and a status byte over a valid/ready transmit handshake. It sits between the serial RX/TX byte interfaces and the arithmetic unit, and it owns the ALU clock-gate enable.

---
 rtl/alu_cmd_ctrl_if.sv | 57 +++++
 rtl/alu_cmd_ctrl.sv | 175 +++++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_ctrl_if.sv
// Byte stream and ALU control bundle for alu_cmd_ctrl.
// slave is the controller side, master is the surrounding system.
interface alu_cmd_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_drop;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_fun;
    logic             arith_enable;
    logic             alu_clk_en;
    logic [WIDTH-1:0] arith_out;
    logic             carry_out;
    logic             arith_flag;
    logic             busy;

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  tx_ready,
        input  arith_out,
        input  carry_out,
        input  arith_flag,
        output rx_drop,
        output tx_data,
        output tx_valid,
        output alu_a,
        output alu_b,
        output alu_fun,
        output arith_enable,
        output alu_clk_en,
        output busy
    );

    modport master (
        output rx_data,
        output rx_valid,
        output tx_ready,
        output arith_out,
        output carry_out,
        output arith_flag,
        input  rx_drop,
        input  tx_data,
        input  tx_valid,
        input  alu_a,
        input  alu_b,
        input  alu_fun,
        input  arith_enable,
        input  alu_clk_en,
        input  busy
    );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Byte command sequencer for the registered ALU: collects A/B/fun,
// pulses the ALU enable once, returns result and status bytes.
module alu_cmd_ctrl #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] CMD_OP   = 8'hCC,
    parameter logic [WIDTH-1:0] CMD_REOP = 8'hDD
) (
    input logic         CLK,
    input logic         RST,
    alu_cmd_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        GET_A,
        GET_B,
        GET_FUN,
        ALU_RUN,
        ALU_WAIT,
        SEND_RES,
        SEND_STAT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       fun_q, fun_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;
    logic             flag_q, flag_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             arith_en_q, arith_en_d;
    logic             clk_en_q, clk_en_d;
    logic             busy_q, busy_d;
    logic             drop;
    logic             tx_fire;

    assign tx_fire = tx_valid_q & bus.tx_ready;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        fun_d   = fun_q;
        res_d   = res_q;
        carry_d = carry_q;
        err_d   = err_q;
        flag_d  = flag_q;
        drop    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == CMD_OP) begin
                        state_d = GET_A;
                    end else if (bus.rx_data == CMD_REOP) begin
                        state_d = GET_FUN;
                    end
                end
            end
            GET_A: begin
                if (bus.rx_valid) begin
                    a_d     = bus.rx_data;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (bus.rx_valid) begin
                    b_d     = bus.rx_data;
                    state_d = GET_FUN;
                end
            end
            GET_FUN: begin
                if (bus.rx_valid) begin
                    fun_d = bus.rx_data[1:0];
                    // Divide by zero is answered locally; the ALU never runs.
                    if (bus.rx_data[1:0] == 2'b11 && b_q == '0) begin
                        res_d   = '1;
                        err_d   = 1'b1;
                        carry_d = 1'b0;
                        flag_d  = 1'b0;
                        state_d = SEND_RES;
                    end else begin
                        state_d = ALU_RUN;
                    end
                end
            end
            ALU_RUN: begin
                drop    = bus.rx_valid;
                state_d = ALU_WAIT;
            end
            ALU_WAIT: begin
                drop    = bus.rx_valid;
                res_d   = bus.arith_out;
                carry_d = bus.carry_out;
                flag_d  = bus.arith_flag;
                err_d   = 1'b0;
                state_d = SEND_RES;
            end
            SEND_RES: begin
                drop = bus.rx_valid;
                if (tx_fire) begin
                    state_d = SEND_STAT;
                end
            end
            SEND_STAT: begin
                drop = bus.rx_valid;
                if (tx_fire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they leave a flop.
    always_comb begin
        tx_valid_d = (state_d == SEND_RES) || (state_d == SEND_STAT);
        arith_en_d = (state_d == ALU_RUN);
        clk_en_d   = (state_d == ALU_RUN) || (state_d == ALU_WAIT);
        busy_d     = (state_d != IDLE);
        tx_data_d  = '0;
        if (state_d == SEND_RES) begin
            tx_data_d = res_d;
        end else if (state_d == SEND_STAT) begin
            tx_data_d = {{(WIDTH-3){1'b0}}, flag_d, err_d, carry_d};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            fun_q      <= '0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            err_q      <= 1'b0;
            flag_q     <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            arith_en_q <= 1'b0;
            clk_en_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            fun_q      <= fun_d;
            res_q      <= res_d;
            carry_q    <= carry_d;
            err_q      <= err_d;
            flag_q     <= flag_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            arith_en_q <= arith_en_d;
            clk_en_q   <= clk_en_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.tx_data      = tx_data_q;
    assign bus.tx_valid     = tx_valid_q;
    assign bus.alu_a        = a_q;
    assign bus.alu_b        = b_q;
    assign bus.alu_fun      = fun_q;
    assign bus.arith_enable = arith_en_q;
    assign bus.alu_clk_en   = clk_en_q;
    assign bus.busy         = busy_q;
    assign bus.rx_drop      = drop;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Scoreboard bench for alu_cmd_ctrl with a behavioural ALU and
// an arithmetic reference model for the expected tx bytes.
module tb_alu_cmd_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    always #5 CLK = ~CLK;

    alu_cmd_ctrl_if #(.WIDTH(8)) bus ();

    alu_cmd_ctrl #(
        .WIDTH   (8),
        .CMD_OP  (8'hCC),
        .CMD_REOP(8'hDD)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int ready_mode  = 0;
    int en_cnt      = 0;
    int clken_cnt   = 0;
    logic flag_mode = 1'b0;
    logic [7:0] exp_q[$];
    int unsigned mA = 0;
    int unsigned mB = 0;

    // Registered ALU stand-in
    logic [7:0]  alu_out_r = 8'h00;
    logic        alu_c_r   = 1'b0;
    logic        alu_f_r   = 1'b0;
    logic [15:0] prod;
    assign prod = {8'h00, bus.alu_a} * {8'h00, bus.alu_b};

    always @(posedge CLK) begin
        if (bus.arith_enable) begin
            case (bus.alu_fun)
                2'd0: {alu_c_r, alu_out_r} <= {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                2'd1: {alu_c_r, alu_out_r} <= {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
                2'd2: begin
                    alu_out_r <= prod[7:0];
                    alu_c_r   <= |prod[15:8];
                end
                default: begin
                    alu_out_r <= (bus.alu_b != 0) ? bus.alu_a / bus.alu_b : 8'hFF;
                    alu_c_r   <= 1'b0;
                end
            endcase
            alu_f_r <= flag_mode;
        end
    end

    assign bus.arith_out  = alu_out_r;
    assign bus.carry_out  = alu_c_r;
    assign bus.arith_flag = alu_f_r;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // tx_ready driver: 0 high, 1 random, 2 low, 3 one-cycle pulse
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (ready_mode)
                0: bus.tx_ready = 1'b1;
                1: bus.tx_ready = 1'($urandom_range(0, 1));
                3: begin
                    bus.tx_ready = 1'b1;
                    ready_mode   = 2;
                end
                default: bus.tx_ready = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (bus.arith_enable) en_cnt++;
            if (bus.alu_clk_en) clken_cnt++;
        end
    end

    // Monitor: pops expected bytes on every tx handshake
    initial begin
        logic [7:0] prev;
        logic       prev_stall;
        logic [7:0] e;
        prev       = 8'h00;
        prev_stall = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && bus.tx_valid)
                    chk("tx_hold", 32'(bus.tx_data), 32'(prev));
                if (bus.tx_valid && bus.tx_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_tx");
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_byte", 32'(bus.tx_data), 32'(e));
                    end
                end
                prev_stall = bus.tx_valid && !bus.tx_ready;
                prev       = bus.tx_data;
            end
        end
    end

    // Reference model: push result and status for one command
    task automatic expect_cmd(input bit is_op, input logic [7:0] a,
                              input logic [7:0] b, input logic [1:0] f);
        int unsigned r;
        int unsigned res;
        bit c;
        bit err;
        bit fl;
        if (is_op) begin
            mA = a;
            mB = b;
        end
        c   = 0;
        err = 0;
        fl  = flag_mode;
        case (f)
            2'd0: begin
                r   = mA + mB;
                res = r % 256;
                c   = (r > 255);
            end
            2'd1: begin
                res = (mA + 256 - mB) % 256;
                c   = (mA < mB);
            end
            2'd2: begin
                r   = mA * mB;
                res = r % 256;
                c   = (r > 255);
            end
            default: begin
                if (mB == 0) begin
                    res = 255;
                    err = 1;
                    fl  = 0;
                end else begin
                    res = mA / mB;
                end
            end
        endcase
        exp_q.push_back(8'(res));
        exp_q.push_back({5'b0, fl, err, c});
    endtask

    task automatic send_byte(input logic [7:0] d);
        @(posedge CLK);
        #1;
        bus.rx_data  = d;
        bus.rx_valid = 1'b1;
        @(posedge CLK);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic issue(input bit is_op, input logic [7:0] a,
                         input logic [7:0] b, input logic [1:0] f);
        expect_cmd(is_op, a, b, f);
        if (is_op) begin
            send_byte(8'hCC);
            send_byte(a);
            send_byte(b);
        end else begin
            send_byte(8'hDD);
        end
        send_byte({6'b0, f});
    endtask

    task automatic wait_empty();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(posedge CLK);
            t++;
        end
        if (exp_q.size() != 0) begin
            fail_now("resp_timeout");
            exp_q.delete();
        end
    endtask

    task automatic wait_txv();
        int t;
        t = 0;
        @(negedge CLK);
        while (!bus.tx_valid && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (!bus.tx_valid) fail_now("tx_valid_timeout");
    endtask

    task automatic inject(input logic [7:0] d, input logic exp_drop,
                          input string name);
        @(posedge CLK);
        #1;
        bus.rx_data  = d;
        bus.rx_valid = 1'b1;
        @(negedge CLK);
        chk(name, 32'(bus.rx_drop), 32'(exp_drop));
        @(posedge CLK);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk(name, {1'b0, bus.tx_valid, bus.tx_data, bus.alu_a, bus.alu_b,
                   bus.alu_fun, bus.arith_enable, bus.alu_clk_en,
                   bus.busy, bus.rx_drop}, 32'h0);
    endtask

    task automatic do_reset();
        #2;
        RST = 1'b0;
        #1;
        chk_zero("reset_outs");
        exp_q.delete();
        mA = 0;
        mB = 0;
        repeat (2) @(negedge CLK);
        chk_zero("reset_hold");
        RST = 1'b1;
    endtask

    initial begin
        int e0;
        int c0;
        bit op;
        logic [7:0] ra;
        logic [7:0] rb;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        repeat (3) @(negedge CLK);
        chk_zero("reset_state");
        RST = 1'b1;

        // Add with latency checks
        e0 = en_cnt;
        c0 = clken_cnt;
        issue(1, 8'h05, 8'h03, 2'd0);
        @(negedge CLK);
        chk("en_after_fun", 32'(bus.arith_enable), 32'd1);
        @(negedge CLK);
        chk("en_one_cycle", 32'(bus.arith_enable), 32'd0);
        chk("txv_wait", 32'(bus.tx_valid), 32'd0);
        @(negedge CLK);
        chk("txv_res", 32'(bus.tx_valid), 32'd1);
        wait_empty();
        chk("en_count_add", 32'(en_cnt - e0), 32'd1);
        chk("clken_count_add", 32'(clken_cnt - c0), 32'd2);

        issue(1, 8'hF0, 8'h20, 2'd0);
        wait_empty();
        issue(1, 8'h03, 8'h05, 2'd1);
        wait_empty();
        issue(1, 8'h10, 8'h10, 2'd2);
        wait_empty();
        issue(0, 8'h00, 8'h00, 2'd0);
        wait_empty();

        // Divide by zero under backpressure
        e0 = en_cnt;
        c0 = clken_cnt;
        ready_mode = 2;
        issue(1, 8'h09, 8'h00, 2'd3);
        wait_txv();
        repeat (5) @(negedge CLK);
        ready_mode = 0;
        wait_empty();
        chk("en_count_div0", 32'(en_cnt - e0), 32'd0);
        chk("clken_count_div0", 32'(clken_cnt - c0), 32'd0);

        // Ignore in IDLE, drop in SEND_RES
        inject(8'h55, 1'b0, "idle_no_drop");
        @(negedge CLK);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        ready_mode = 2;
        issue(1, 8'h05, 8'h03, 2'd0);
        wait_txv();
        inject(8'h77, 1'b1, "send_res_drop");
        ready_mode = 0;
        wait_empty();

        // Reset during GET_B
        send_byte(8'hCC);
        send_byte(8'h11);
        do_reset();
        issue(0, 8'h00, 8'h00, 2'd0);
        wait_empty();

        // Reset during SEND_STAT
        ready_mode = 2;
        issue(1, 8'h07, 8'h02, 2'd0);
        wait_txv();
        ready_mode = 3;
        begin
            int t;
            t = 0;
            while (exp_q.size() > 1 && t < 50) begin
                @(negedge CLK);
                t++;
            end
            if (exp_q.size() > 1) fail_now("stat_timeout");
        end
        @(negedge CLK);
        chk("stat_pending", 32'(bus.tx_valid), 32'd1);
        do_reset();
        ready_mode = 0;
        repeat (3) @(negedge CLK);
        chk("no_tx_after_rst", 32'(bus.tx_valid), 32'd0);
        issue(0, 8'h00, 8'h00, 2'd0);
        wait_empty();

        // Randomized commands
        for (int i = 0; i < 40; i++) begin
            flag_mode  = 1'($urandom_range(0, 1));
            ready_mode = int'($urandom_range(0, 1));
            op = ($urandom_range(0, 3) != 0);
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            issue(op, ra, rb, 2'($urandom_range(0, 3)));
            wait_empty();
        end
        ready_mode = 0;
        repeat (3) @(negedge CLK);
        chk("final_idle", 32'(bus.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
